// File: rtl/axis_adapter_wrapper_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axis_interface: AXI4-Stream bundle with shared clock and reset   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface axis_interface #(
   parameter int DATA_WIDTH = 8
) (
   input logic clk,
   input logic rst
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;
   logic [7:0]              tid;
   logic [7:0]              tdest;
   logic [0:0]              tuser;

   modport Sink (
      input  clk, rst, tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
      output tready
   );

   modport Source (
      input  clk, rst, tready,
      output tdata, tkeep, tvalid, tlast, tid, tdest, tuser
   );
endinterface
`default_nettype wire

// File: rtl/axis_adapter_wrapper.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axis_adapter_wrapper: AXI4-Stream width converter (up/down/equal)|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axis_adapter_wrapper #(
   parameter int S_DATA_WIDTH = 16,
   parameter int M_DATA_WIDTH = 8
) (
   axis_interface.Sink   original_data,
   axis_interface.Source modified_width_data
);
   logic w_clk;
   logic w_rst;
   logic w_m_ready;
   logic r_run;

   assign w_clk     = original_data.clk;
   assign w_rst     = original_data.rst;
   assign w_m_ready = modified_width_data.tready;

   // Holds tready low for the cycle that follows any reset edge.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   generate
      if (S_DATA_WIDTH > M_DATA_WIDTH) begin : g_down
         localparam int RATIO  = S_DATA_WIDTH / M_DATA_WIDTH;
         localparam int SEG_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
         localparam int S_KEEP = S_DATA_WIDTH / 8;
         localparam int M_KEEP = M_DATA_WIDTH / 8;

         logic [S_DATA_WIDTH-1:0] r_data;
         logic [S_KEEP-1:0]       r_keep;
         logic [SEG_W-1:0]        r_seg;
         logic [SEG_W-1:0]        r_hi;
         logic                    r_valid;
         logic                    r_last;
         logic [7:0]              r_id;
         logic [7:0]              r_dest;
         logic [0:0]              r_user;
         logic [SEG_W-1:0]        w_hi;
         logic                    w_final;
         logic                    w_m_xfer;
         logic                    w_ready;
         logic                    w_accept;

         // Highest segment carrying any valid byte; segment 0 if none.
         always_comb begin
            w_hi = '0;
            for (int k = 0; k < RATIO; k++) begin
               if (|original_data.tkeep[k*M_KEEP +: M_KEEP]) begin
                  w_hi = SEG_W'(k);
               end
            end
         end

         assign w_final  = (r_seg == r_hi);
         assign w_m_xfer = r_valid && w_m_ready;
         assign w_ready  = r_run && !w_rst && (!r_valid || (w_m_xfer && w_final));
         assign w_accept = original_data.tvalid && w_ready;

         always_ff @(posedge w_clk) begin
            if (w_rst) begin
               r_data  <= '0;
               r_keep  <= '0;
               r_seg   <= '0;
               r_hi    <= '0;
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_id    <= '0;
               r_dest  <= '0;
               r_user  <= '0;
            end else begin
               if (w_m_xfer) begin
                  if (w_final) begin
                     r_valid <= 1'b0;
                     r_seg   <= '0;
                  end else begin
                     r_seg <= r_seg + SEG_W'(1);
                  end
               end
               if (w_accept) begin
                  r_data  <= original_data.tdata;
                  r_keep  <= original_data.tkeep;
                  r_hi    <= w_hi;
                  r_seg   <= '0;
                  r_valid <= 1'b1;
                  r_last  <= original_data.tlast;
                  r_id    <= original_data.tid;
                  r_dest  <= original_data.tdest;
                  r_user  <= original_data.tuser;
               end
            end
         end

         assign original_data.tready       = w_ready;
         assign modified_width_data.tvalid = r_valid;
         assign modified_width_data.tdata  = r_data[r_seg*M_DATA_WIDTH +: M_DATA_WIDTH];
         assign modified_width_data.tkeep  = r_keep[r_seg*M_KEEP +: M_KEEP];
         assign modified_width_data.tlast  = r_last && w_final;
         assign modified_width_data.tid    = r_id;
         assign modified_width_data.tdest  = r_dest;
         assign modified_width_data.tuser  = r_user;
      end else if (M_DATA_WIDTH > S_DATA_WIDTH) begin : g_up
         localparam int RATIO  = M_DATA_WIDTH / S_DATA_WIDTH;
         localparam int CNT_W  = $clog2(RATIO);
         localparam int S_KEEP = S_DATA_WIDTH / 8;
         localparam int M_KEEP = M_DATA_WIDTH / 8;

         logic [M_DATA_WIDTH-1:0] r_data;
         logic [M_KEEP-1:0]       r_keep;
         logic [CNT_W-1:0]        r_cnt;
         logic                    r_valid;
         logic                    r_last;
         logic [7:0]              r_id;
         logic [7:0]              r_dest;
         logic [0:0]              r_user;
         logic [M_DATA_WIDTH-1:0] w_data_nxt;
         logic [M_KEEP-1:0]       w_keep_nxt;
         logic                    w_m_xfer;
         logic                    w_ready;
         logic                    w_accept;
         logic                    w_done;

         assign w_m_xfer = r_valid && w_m_ready;
         assign w_ready  = r_run && !w_rst && (!r_valid || w_m_xfer);
         assign w_accept = original_data.tvalid && w_ready;
         assign w_done   = w_accept && (original_data.tlast || (r_cnt == CNT_W'(RATIO - 1)));

         // A word leaving clears the register so unfilled lanes of the next word stay zero.
         always_comb begin
            w_data_nxt = w_m_xfer ? '0 : r_data;
            w_keep_nxt = w_m_xfer ? '0 : r_keep;
            if (w_accept) begin
               w_data_nxt[r_cnt*S_DATA_WIDTH +: S_DATA_WIDTH] = original_data.tdata;
               w_keep_nxt[r_cnt*S_KEEP +: S_KEEP]             = original_data.tkeep;
            end
         end

         always_ff @(posedge w_clk) begin
            if (w_rst) begin
               r_data  <= '0;
               r_keep  <= '0;
               r_cnt   <= '0;
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_id    <= '0;
               r_dest  <= '0;
               r_user  <= '0;
            end else begin
               r_data <= w_data_nxt;
               r_keep <= w_keep_nxt;
               if (w_done) begin
                  r_valid <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  if (w_m_xfer) begin
                     r_valid <= 1'b0;
                  end
                  if (w_accept) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               if (w_accept) begin
                  r_last <= original_data.tlast;
                  r_id   <= original_data.tid;
                  r_dest <= original_data.tdest;
                  r_user <= original_data.tuser;
               end
            end
         end

         assign original_data.tready       = w_ready;
         assign modified_width_data.tvalid = r_valid;
         assign modified_width_data.tdata  = r_data;
         assign modified_width_data.tkeep  = r_keep;
         assign modified_width_data.tlast  = r_last;
         assign modified_width_data.tid    = r_id;
         assign modified_width_data.tdest  = r_dest;
         assign modified_width_data.tuser  = r_user;
      end else begin : g_equal
         localparam int KEEP_W = S_DATA_WIDTH / 8;

         logic [S_DATA_WIDTH-1:0] r_data;
         logic [KEEP_W-1:0]       r_keep;
         logic                    r_valid;
         logic                    r_last;
         logic [7:0]              r_id;
         logic [7:0]              r_dest;
         logic [0:0]              r_user;
         logic                    w_ready;
         logic                    w_accept;

         assign w_ready  = r_run && !w_rst && (!r_valid || w_m_ready);
         assign w_accept = original_data.tvalid && w_ready;

         always_ff @(posedge w_clk) begin
            if (w_rst) begin
               r_data  <= '0;
               r_keep  <= '0;
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_id    <= '0;
               r_dest  <= '0;
               r_user  <= '0;
            end else begin
               if (w_accept) begin
                  r_valid <= 1'b1;
                  r_data  <= original_data.tdata;
                  r_keep  <= original_data.tkeep;
                  r_last  <= original_data.tlast;
                  r_id    <= original_data.tid;
                  r_dest  <= original_data.tdest;
                  r_user  <= original_data.tuser;
               end else if (w_m_ready) begin
                  r_valid <= 1'b0;
               end
            end
         end

         assign original_data.tready       = w_ready;
         assign modified_width_data.tvalid = r_valid;
         assign modified_width_data.tdata  = r_data;
         assign modified_width_data.tkeep  = r_keep;
         assign modified_width_data.tlast  = r_last;
         assign modified_width_data.tid    = r_id;
         assign modified_width_data.tdest  = r_dest;
         assign modified_width_data.tuser  = r_user;
      end
   endgenerate
endmodule
`default_nettype wire

// File: tb/tb_axis_adapter_wrapper.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axis_adapter_wrapper: 16->8 and 8->16 converters vs. model    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_axis_adapter_wrapper;
   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  k;
      logic        l;
      logic [7:0]  id;
      logic [7:0]  dest;
      logic        u;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axis_interface #(.DATA_WIDTH(16)) dn_s (.clk(clk), .rst(rst));
   axis_interface #(.DATA_WIDTH(8))  dn_m (.clk(clk), .rst(rst));
   axis_interface #(.DATA_WIDTH(8))  up_s (.clk(clk), .rst(rst));
   axis_interface #(.DATA_WIDTH(16)) up_m (.clk(clk), .rst(rst));

   axis_adapter_wrapper #(.S_DATA_WIDTH(16), .M_DATA_WIDTH(8)) u_dn (
      .original_data       (dn_s),
      .modified_width_data (dn_m)
   );
   axis_adapter_wrapper #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(16)) u_up (
      .original_data       (up_s),
      .modified_width_data (up_m)
   );

   int    checks = 0;
   int    fails  = 0;
   int    cyc    = 0;
   beat_t dn_q[$];
   beat_t up_q[$];
   logic [15:0] up_acc_d = '0;
   logic [1:0]  up_acc_k = '0;
   int    up_n = 0;
   logic  dn_sfire = 1'b0, up_sfire = 1'b0;
   logic  dn_stall = 1'b0, up_stall = 1'b0;
   beat_t dn_prev, up_prev;
   int    dn_fires = 0, up_fires = 0;
   logic  gap_chk = 1'b0;
   int    gap_n = 0, gap_last = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
      end
   endtask

   task automatic cmp_beat(input string tag, input beat_t obs, input beat_t req);
      chk({tag, ".tdata"}, 32'(obs.d),    32'(req.d));
      chk({tag, ".tkeep"}, 32'(obs.k),    32'(req.k));
      chk({tag, ".tlast"}, 32'(obs.l),    32'(req.l));
      chk({tag, ".tid"},   32'(obs.id),   32'(req.id));
      chk({tag, ".tdest"}, 32'(obs.dest), 32'(req.dest));
      chk({tag, ".tuser"}, 32'(obs.u),    32'(req.u));
   endtask

   // Downsizer reference: emit byte segments 0..highest-kept, tlast only on the final one.
   task automatic model_dn();
      beat_t o;
      int    hi;
      hi = dn_s.tkeep[1] ? 1 : 0;
      for (int s = 0; s <= hi; s++) begin
         o      = '0;
         o.d    = {8'h00, (s == 0) ? dn_s.tdata[7:0] : dn_s.tdata[15:8]};
         o.k    = {1'b0, dn_s.tkeep[s]};
         o.l    = dn_s.tlast && (s == hi);
         o.id   = dn_s.tid;
         o.dest = dn_s.tdest;
         o.u    = dn_s.tuser[0];
         dn_q.push_back(o);
      end
   endtask

   // Upsizer reference: pack bytes from lane 0, flush on two bytes or tlast.
   task automatic model_up();
      beat_t o;
      up_acc_d[8*up_n +: 8] = up_s.tdata;
      up_acc_k[up_n]        = up_s.tkeep[0];
      up_n++;
      if (up_n == 2 || up_s.tlast) begin
         o      = '0;
         o.d    = up_acc_d;
         o.k    = up_acc_k;
         o.l    = up_s.tlast;
         o.id   = up_s.tid;
         o.dest = up_s.tdest;
         o.u    = up_s.tuser[0];
         up_q.push_back(o);
         up_acc_d = '0;
         up_acc_k = '0;
         up_n     = 0;
      end
   endtask

   task automatic tick();
      beat_t od, ou;
      #1;
      dn_sfire = 1'b0;
      up_sfire = 1'b0;
      od = {{8'h00, dn_m.tdata}, {1'b0, dn_m.tkeep}, dn_m.tlast, dn_m.tid, dn_m.tdest, dn_m.tuser[0]};
      ou = {up_m.tdata, up_m.tkeep, up_m.tlast, up_m.tid, up_m.tdest, up_m.tuser[0]};
      if (rst) begin
         dn_q.delete();
         up_q.delete();
         up_acc_d = '0;
         up_acc_k = '0;
         up_n     = 0;
         dn_stall = 1'b0;
         up_stall = 1'b0;
      end else begin
         if (dn_stall) begin
            chk("dn_hold_tvalid", 32'(dn_m.tvalid), 32'(1));
            cmp_beat("dn_hold", od, dn_prev);
         end
         if (up_stall) begin
            chk("up_hold_tvalid", 32'(up_m.tvalid), 32'(1));
            cmp_beat("up_hold", ou, up_prev);
         end
         if (dn_s.tvalid && dn_s.tready) begin
            dn_sfire = 1'b1;
            model_dn();
         end
         if (up_s.tvalid && up_s.tready) begin
            up_sfire = 1'b1;
            model_up();
         end
         if (dn_m.tvalid && dn_m.tready) begin
            dn_fires++;
            if (gap_chk) begin
               if (gap_n > 0) chk("dn_no_bubble_cycle", 32'(cyc), 32'(gap_last + 1));
               gap_n++;
               gap_last = cyc;
            end
            chk("dn_beat_expected", 32'(dn_q.size() > 0), 32'(1));
            if (dn_q.size() > 0) cmp_beat("dn_out", od, dn_q.pop_front());
         end
         if (up_m.tvalid && up_m.tready) begin
            up_fires++;
            chk("up_beat_expected", 32'(up_q.size() > 0), 32'(1));
            if (up_q.size() > 0) cmp_beat("up_out", ou, up_q.pop_front());
         end
         dn_stall = dn_m.tvalid && !dn_m.tready;
         up_stall = up_m.tvalid && !up_m.tready;
         dn_prev  = od;
         up_prev  = ou;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic send_dn(input logic [15:0] d, input logic [1:0] k, input logic l);
      int n;
      n            = 0;
      dn_s.tvalid  = 1'b1;
      dn_s.tdata   = d;
      dn_s.tkeep   = k;
      dn_s.tlast   = l;
      dn_s.tid     = 8'($urandom);
      dn_s.tdest   = 8'($urandom);
      dn_s.tuser   = 1'($urandom);
      do begin
         tick();
         n++;
      end while (!dn_sfire && n < 50);
      chk("dn_accept_in_time", 32'(dn_sfire), 32'(1));
      dn_s.tvalid = 1'b0;
   endtask

   task automatic send_up(input logic [7:0] d, input logic k, input logic l);
      int n;
      n            = 0;
      up_s.tvalid  = 1'b1;
      up_s.tdata   = d;
      up_s.tkeep   = k;
      up_s.tlast   = l;
      up_s.tid     = 8'($urandom);
      up_s.tdest   = 8'($urandom);
      up_s.tuser   = 1'($urandom);
      do begin
         tick();
         n++;
      end while (!up_sfire && n < 50);
      chk("up_accept_in_time", 32'(up_sfire), 32'(1));
      up_s.tvalid = 1'b0;
   endtask

   initial begin
      int f0;
      int n;
      dn_s.tvalid = 1'b0; dn_s.tdata = '0; dn_s.tkeep = '0; dn_s.tlast = 1'b0;
      dn_s.tid = '0; dn_s.tdest = '0; dn_s.tuser = '0;
      up_s.tvalid = 1'b0; up_s.tdata = '0; up_s.tkeep = '0; up_s.tlast = 1'b0;
      up_s.tid = '0; up_s.tdest = '0; up_s.tuser = '0;
      dn_m.tready = 1'b0;
      up_m.tready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // Reset state
      chk("rst_dn_tvalid", 32'(dn_m.tvalid), 32'(0));
      chk("rst_dn_tdata",  32'(dn_m.tdata),  32'(0));
      chk("rst_dn_tkeep",  32'(dn_m.tkeep),  32'(0));
      chk("rst_dn_tlast",  32'(dn_m.tlast),  32'(0));
      chk("rst_dn_tready", 32'(dn_s.tready), 32'(0));
      chk("rst_up_tvalid", 32'(up_m.tvalid), 32'(0));
      chk("rst_up_tdata",  32'(up_m.tdata),  32'(0));
      chk("rst_up_tready", 32'(up_s.tready), 32'(0));
      rst = 1'b0;
      tick();
      chk("dn_tready_after_rst", 32'(dn_s.tready), 32'(1));
      chk("up_tready_after_rst", 32'(up_s.tready), 32'(1));

      // 16->8 full beat
      dn_m.tready = 1'b1;
      f0 = dn_fires;
      send_dn(16'h6971, 2'b11, 1'b1);
      chk("dn_first_seg_valid", 32'(dn_m.tvalid), 32'(1));
      chk("dn_first_seg_data",  32'(dn_m.tdata),  32'h71);
      repeat (4) tick();
      chk("dn_full_beats", 32'(dn_fires - f0), 32'(2));
      chk("dn_full_drained", 32'(dn_q.size()), 32'(0));

      // 16->8 backpressure
      dn_m.tready = 1'b0;
      f0 = dn_fires;
      send_dn(16'h6971, 2'b11, 1'b1);
      repeat (5) begin
         chk("dn_bp_tvalid", 32'(dn_m.tvalid), 32'(1));
         chk("dn_bp_tdata",  32'(dn_m.tdata),  32'h71);
         tick();
      end
      dn_m.tready = 1'b1;
      repeat (4) tick();
      chk("dn_bp_beats", 32'(dn_fires - f0), 32'(2));
      chk("dn_bp_drained", 32'(dn_q.size()), 32'(0));

      // 16->8 partial keep
      f0 = dn_fires;
      send_dn(16'h6971, 2'b01, 1'b1);
      chk("dn_part_tlast", 32'(dn_m.tlast), 32'(1));
      repeat (4) tick();
      chk("dn_part_beats", 32'(dn_fires - f0), 32'(1));

      // 8->16 packing
      up_m.tready = 1'b1;
      f0 = up_fires;
      send_up(8'h71, 1'b1, 1'b0);
      send_up(8'h69, 1'b1, 1'b1);
      chk("up_pair_tdata", 32'(up_m.tdata), 32'h6971);
      chk("up_pair_tkeep", 32'(up_m.tkeep), 32'(2'b11));
      send_up(8'hAB, 1'b1, 1'b1);
      chk("up_short_tdata", 32'(up_m.tdata), 32'h00AB);
      chk("up_short_tkeep", 32'(up_m.tkeep), 32'(2'b01));
      repeat (4) tick();
      chk("up_beats", 32'(up_fires - f0), 32'(2));
      chk("up_drained", 32'(up_q.size()), 32'(0));

      // 16->8 reset after first segment, then back-to-back beats
      dn_m.tready = 1'b0;
      send_dn(16'h6971, 2'b11, 1'b1);
      dn_m.tready = 1'b1;
      tick();
      dn_m.tready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_tvalid", 32'(dn_m.tvalid), 32'(0));
      tick();
      chk("rst_mid_tready", 32'(dn_s.tready), 32'(1));
      chk("rst_mid_no_69",  32'(dn_m.tvalid), 32'(0));
      dn_m.tready = 1'b1;
      gap_chk = 1'b1;
      gap_n   = 0;
      f0 = dn_fires;
      send_dn(16'h1122, 2'b11, 1'b0);
      send_dn(16'h3344, 2'b11, 1'b1);
      repeat (6) tick();
      gap_chk = 1'b0;
      chk("b2b_beats", 32'(dn_fires - f0), 32'(4));
      chk("b2b_drained", 32'(dn_q.size()), 32'(0));

      // Randomized traffic on both converters, with one reset in the middle
      for (int i = 0; i < 600; i++) begin
         if (!dn_s.tvalid && $urandom_range(0, 3) != 0) begin
            dn_s.tvalid = 1'b1;
            dn_s.tdata  = 16'($urandom);
            dn_s.tkeep  = 2'($urandom);
            dn_s.tlast  = 1'($urandom);
            dn_s.tid    = 8'($urandom);
            dn_s.tdest  = 8'($urandom);
            dn_s.tuser  = 1'($urandom);
         end
         if (!up_s.tvalid && $urandom_range(0, 3) != 0) begin
            up_s.tvalid = 1'b1;
            up_s.tdata  = 8'($urandom);
            up_s.tkeep  = 1'($urandom);
            up_s.tlast  = ($urandom_range(0, 2) == 0);
            up_s.tid    = 8'($urandom);
            up_s.tdest  = 8'($urandom);
            up_s.tuser  = 1'($urandom);
         end
         dn_m.tready = ($urandom_range(0, 2) != 0);
         up_m.tready = ($urandom_range(0, 2) != 0);
         if (i == 300) begin
            rst = 1'b1;
            dn_m.tready = 1'b0;
            up_m.tready = 1'b0;
         end
         tick();
         rst = 1'b0;
         if (dn_sfire) dn_s.tvalid = 1'b0;
         if (up_sfire) up_s.tvalid = 1'b0;
      end

      dn_m.tready = 1'b1;
      up_m.tready = 1'b1;
      n = 0;
      while ((dn_s.tvalid || up_s.tvalid) && n < 50) begin
         tick();
         if (dn_sfire) dn_s.tvalid = 1'b0;
         if (up_sfire) up_s.tvalid = 1'b0;
         n++;
      end
      chk("rand_inputs_drained", 32'(dn_s.tvalid || up_s.tvalid), 32'(0));
      repeat (8) tick();
      chk("rand_dn_drained", 32'(dn_q.size()), 32'(0));
      chk("rand_up_drained", 32'(up_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/axis_adapter_wrapper.md
AXIS_ADAPTER_WRAPPER -- requirements
Module: axis_adapter_wrapper

Interface
REQ-001 SHALL take parameter S_DATA_WIDTH, default 16: sink tdata width in bits; a multiple of 8.
REQ-002 SHALL take parameter M_DATA_WIDTH, default 8: source tdata width in bits; a multiple of 8; the larger of S_DATA_WIDTH and M_DATA_WIDTH is an integer multiple of the smaller.
REQ-003 SHALL expose exactly two ports, both of type axis_interface.
  - original_data: Sink modport, DATA_WIDTH = S_DATA_WIDTH.
  - modified_width_data: Source modport, DATA_WIDTH = M_DATA_WIDTH.
  - axis_interface carries clk, rst, tdata, tvalid, tready, tlast, tkeep (DATA_WIDTH/8), tid (8), tdest (8), tuser (1).
REQ-004 clk  input  1  single clock, taken from original_data.clk; both interfaces share it; everything is synchronous to its rising edge.
REQ-005 rst  input  1  reset, taken from original_data.rst; synchronous, active-high.
REQ-006 original_data.tdata/tkeep/tvalid/tlast/tid/tdest/tuser  input  S-side widths  incoming stream; original_data.tready is an output.
REQ-007 modified_width_data.tdata/tkeep/tvalid/tlast/tid/tdest/tuser  output  M-side widths  outgoing stream; modified_width_data.tready is an input.

Function
REQ-008 SHALL transfer a beat on either side only in a cycle where tvalid and tready are both 1.
REQ-009 SHALL hold all source payload signals stable while modified_width_data.tvalid=1 and tready=0.
REQ-010 SHALL never deassert modified_width_data.tvalid before the beat transfers.
REQ-011 Lane order SHALL be little-endian: byte lane 0 = tdata[7:0] is the first byte in time.
REQ-012 Downsizing (S > M), ratio R = S/M:
  - Each accepted input beat SHALL be registered.
  - Segments SHALL be emitted in ascending order, segment k = tdata[k*M +: M] with its tkeep slice.
  - Emission SHALL stop after the highest segment that has any tkeep bit set; at least one segment is always emitted.
REQ-013 Downsizing: tlast SHALL be 1 only on the final emitted segment of a beat that had tlast=1; tid, tdest and tuser SHALL be replicated on every segment.
REQ-014 Downsizing: first segment valid the cycle after input acceptance.
  - original_data.tready=1 when the buffer is empty, or when the final segment transfers in the same cycle (back-to-back, no bubble).
REQ-015 Upsizing (M > S), ratio R = M/S:
  - Input beats SHALL be packed into lane 0 upward; the output word is presented after R beats, or earlier on tlast=1.
  - Unfilled lanes have tdata=0 and tkeep=0.
  - Output tlast = tlast of the last packed beat; tid/tdest/tuser are taken from the last packed beat.
REQ-016 Upsizing: original_data.tready=1 while the packing register is not holding a complete word, or when that word transfers in the same cycle.
REQ-017 Equal widths: one register stage, full throughput, all fields passed unchanged.
REQ-018 Backpressure SHALL never drop or duplicate data; input tkeep bits above the data width are ignored.

Reset
REQ-019 While rst=1 at a clock edge, the following SHALL be 0 on the next cycle, and any partial beat is discarded:
  - modified_width_data.tvalid, tlast, tdata, tkeep
  - original_data.tready
  - segment/pack counters
REQ-020 The cycle after rst deasserts, original_data.tready SHALL be 1.
REQ-021 rst asserted mid-operation SHALL abort the current beat; no remaining segments are emitted afterwards.

Verification
REQ-022 16->8: input tdata=0x6971, tkeep=2'b11, tlast=1, sink tready=1 -> two output beats: 0x71 (tlast=0), then 0x69 (tlast=1); no further beats.
REQ-023 16->8 backpressure: same input with modified_width_data.tready=0 for 5 cycles -> tdata holds 0x71 with tvalid=1; on release 0x71 then 0x69 are output.
REQ-024 16->8 partial: tdata=0x6971, tkeep=2'b01, tlast=1 -> single beat 0x71, tkeep=1, tlast=1.
REQ-025 8->16: inputs 0x71 (tlast=0) then 0x69 (tlast=1) -> one beat 0x6971, tkeep=2'b11, tlast=1; then 0xAB with tlast=1 -> 0x00AB, tkeep=2'b01, tlast=1.
REQ-026 16->8 reset mid-transfer: rst pulse after the 0x71 transfer -> tvalid=0, 0x69 is never emitted, original_data.tready=1 one cycle after rst falls; back-to-back beats 0x1122 and 0x3344 -> 0x22, 0x11, 0x44, 0x33 with no idle cycle.
